// File: rtl/chunked_adder_pkg.sv
// chunked_adder_pkg: shared FSM states and size helpers for the chunk-serial adder.
// Revision 1.0
`default_nettype none
package chunked_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A zero CHUNK yields 1 so the caller's legality check can report the error itself.
  function automatic int num_chunks(input int width, input int chunk);
    return (chunk < 1) ? 1 : (width / chunk);
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// Revision 1.0
`default_nettype none
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[CHUNK];
  // Carry into the top bit lets the parent form signed overflow on the last chunk.
  assign o_cmsb = w_c[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/chunked_adder.sv
// chunked_adder: add/subtract WIDTH-bit operands CHUNK bits per clock with valid/ready handshakes.
// Revision 1.0
`default_nettype none
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = num_chunks(WIDTH, CHUNK);
  localparam int IW = idx_width(N);

  if ((CHUNK < 1) || (WIDTH < CHUNK) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_bad_params
    $error("chunked_adder: WIDTH must be a nonzero multiple of CHUNK");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK-1:0] w_sum;
  logic [WIDTH-1:0] w_s_upd;
  logic             w_co;
  logic             w_cmsb;
  logic             w_last;

  // Constant-bound loop keeps the chunk mux free of variable part-select arithmetic.
  always_comb begin
    w_ca    = '0;
    w_cb    = '0;
    w_s_upd = r_s;
    for (int k = 0; k < N; k++) begin
      if (r_idx == IW'(k)) begin
        w_ca                         = r_a[k*CHUNK +: CHUNK];
        w_cb                         = r_b[k*CHUNK +: CHUNK];
        w_s_upd[k*CHUNK +: CHUNK]    = w_sum;
      end
    end
  end

  assign w_last = (r_idx == IW'(N - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .i_a    (w_ca),
    .i_b    (w_cb),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_co),
    .o_cmsb (w_cmsb)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= sub | cin;
            r_idx   <= '0;
            r_s     <= '0;
          end
        end
        RUN: begin
          r_s     <= w_s_upd;
          r_carry <= w_co;
          r_idx   <= r_idx + IW'(1);
          if (w_last) begin
            r_cout <= w_co;
            r_ovf  <= w_cmsb ^ w_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE) && !rst;
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: vector table, random ops against an arithmetic model, stall/abort and 8/8 build.
// Revision 1.0
`default_nettype none
module tb_chunked_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0, sub = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] s;

  logic        in_valid8 = 1'b0, out_ready8 = 1'b1, cin8 = 1'b0, sub8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, cout8, ovf8;
  logic [7:0]  s8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  chunked_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  chunked_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .s(s8), .cout(cout8), .ovf(ovf8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the operands' unsigned and signed values.
  function automatic logic [17:0] model(input logic [15:0] ia, ib, input logic icin, isub);
    int ua, ub, sa, sb, ur, sr;
    logic c, o;
    ua = int'(ia); ub = int'(ib);
    sa = int'($signed(ia)); sb = int'($signed(ib));
    if (isub) begin
      ur = ua - ub; sr = sa - sb; c = (ua >= ub);
    end else begin
      ur = ua + ub + int'(icin); sr = sa + sb + int'(icin); c = (ur > 65535);
    end
    o = (sr > 32767) || (sr < -32768);
    return {o, c, ur[15:0]};
  endfunction

  // Offers one operand set, scrambles the inputs after acceptance, waits for out_valid.
  task automatic op(input logic [15:0] ia, ib, input logic icin, isub,
                    output logic [15:0] os, output logic oc, oo, output int lat, output logic rdy);
    @(negedge clk);
    a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = ~icin; sub = ~isub;
    lat = 0;
    for (int k = 2; k <= 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = k; break; end
    end
    os = s; oc = cout; oo = ovf; rdy = 1'b0;
    if (out_ready && lat != 0) begin
      @(posedge clk); #1;
      rdy = in_ready && !out_valid;
    end
  endtask

  typedef struct {
    logic [15:0] va, vb;
    logic        vcin, vsub;
    logic [15:0] es;
    logic        ec, eo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] rs, hs;
    logic        rc, ro, rr, hc, ho;
    logic [17:0] m;
    int          lat, nv;
    string       nm;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

    // Reset behaviour
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_s", {16'd0, s}, 32'd0);
    check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, rs, rc, ro, lat, rr);
      nm = $sformatf("vec%0d", i);
      check({nm, "_s"}, {16'd0, rs}, {16'd0, vecs[i].es});
      check({nm, "_cout"}, {31'd0, rc}, {31'd0, vecs[i].ec});
      check({nm, "_ovf"}, {31'd0, ro}, {31'd0, vecs[i].eo});
      check({nm, "_latency"}, lat, 32'd5);
      check({nm, "_ready_after"}, {31'd0, rr}, 32'd1);
    end

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic        rci, rsb;
      ra = 16'($urandom); rb = 16'($urandom);
      rci = 1'($urandom); rsb = 1'($urandom);
      if (i % 8 == 0) rb = ~ra;
      op(ra, rb, rci, rsb, rs, rc, ro, lat, rr);
      m = model(ra, rb, rci, rsb);
      nm = $sformatf("rnd%0d", i);
      check({nm, "_s"}, {16'd0, rs}, {16'd0, m[15:0]});
      check({nm, "_cout"}, {31'd0, rc}, {31'd0, m[16]});
      check({nm, "_ovf"}, {31'd0, ro}, {31'd0, m[17]});
      if (i % 5 == 0) check({nm, "_latency"}, lat, 32'd5);
    end

    // Stall in DONE with toggling inputs and a pending in_valid
    out_ready = 1'b0;
    op(16'h7FFF, 16'h0000, 1'b1, 1'b0, hs, hc, ho, lat, rr);
    check("stall_latency", lat, 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = ~a; b = ~b; in_valid = 1'b1;
      @(posedge clk); #1;
      check("stall_s", {16'd0, s}, 32'h8000);
      check("stall_cout_ovf", {30'd0, cout, ovf}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release_ready", {31'd0, in_ready}, 32'd1);

    // Reset pulse mid-operation at idx 2
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) nv++;
    end
    check("abort_no_valid", nv, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    op(16'hA5A5, 16'h0F0F, 1'b1, 1'b0, rs, rc, ro, lat, rr);
    m = model(16'hA5A5, 16'h0F0F, 1'b1, 1'b0);
    check("post_abort_s", {16'd0, rs}, {16'd0, m[15:0]});
    check("post_abort_flags", {30'd0, rc, ro}, {30'd0, m[16], m[17]});
    check("post_abort_latency", lat, 32'd5);

    // Single-chunk build
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; sub8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1 in_valid8 = 1'b0;
    check("w8_valid_edge1", {31'd0, out_valid8}, 32'd0);
    @(posedge clk); #1;
    check("w8_valid_edge2", {31'd0, out_valid8}, 32'd1);
    check("w8_s", {24'd0, s8}, 32'd0);
    check("w8_cout_ovf", {30'd0, cout8, ovf8}, 32'd3);
    @(posedge clk); #1;
    check("w8_ready_after", {31'd0, in_ready8}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
